// File: rtl/tlb_search_arbiter.sv
// tlb_search_arbiter: shares the single TLB search port between IF and MEM.
//  - Grants at most one lookup per cycle. MEM normally wins a tie. After STARVE_LIMIT
//    consecutive MEM grants while IF was waiting, the next tie goes to IF.
//  - The TLB result is registered. It is returned to the winner one cycle later as a
//    single-cycle resp_valid pulse. There is no back-pressure on the response.
//  - maint_busy blocks all grants. A response already pending is still delivered.
//  - if_flush blocks an IF grant in the current cycle and squashes an IF response.
// Ports:
//  clk, rst_n                       clock, async active-low reset
//  if_req_valid/ready, if_vppn, if_va_bit12      IF lookup request
//  mem_req_valid/ready, mem_vppn, mem_va_bit12   MEM lookup request
//  asid, maint_busy, if_flush       CSR.ASID, TLB maintenance in flight, IF flush
//  tlb_s_vppn/va_bit12/asid         TLB search port (out)
//  tlb_s_result                     combinational TLB result for this cycle's search
//  if_resp_valid, mem_resp_valid    one-cycle response pulses
//  resp_result                      registered result shared by both responses

package tlb_search_arbiter_pkg;
    typedef struct packed {
        logic        found;
        logic [19:0] ppn;
        logic [5:0]  ps;
        logic [1:0]  plv;
        logic [1:0]  mat;
        logic        d;
        logic        v;
    } tlb_result_t;
endpackage

module tlb_search_arbiter
    import tlb_search_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int ASID_W       = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [18:0]       if_vppn,
    input  logic              if_va_bit12,
    input  logic              mem_req_valid,
    output logic              mem_req_ready,
    input  logic [18:0]       mem_vppn,
    input  logic              mem_va_bit12,
    input  logic [ASID_W-1:0] asid,
    input  logic              maint_busy,
    input  logic              if_flush,
    output logic [18:0]       tlb_s_vppn,
    output logic              tlb_s_va_bit12,
    output logic [ASID_W-1:0] tlb_s_asid,
    input  tlb_result_t       tlb_s_result,
    output logic              if_resp_valid,
    output logic              mem_resp_valid,
    output tlb_result_t       resp_result
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve_cnt;
    logic          if_pend, mem_pend;
    logic          if_elig, grant_if, grant_mem;

    // A flushed IF request is not eligible, so MEM may take the port this cycle.
    assign if_elig = if_req_valid && !if_flush;

    always_comb begin
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        if (!maint_busy) begin
            if (if_elig && mem_req_valid) begin
                grant_if  = (starve_cnt == LIMIT);
                grant_mem = (starve_cnt != LIMIT);
            end else begin
                grant_if  = if_elig;
                grant_mem = mem_req_valid;
            end
        end
    end

    assign if_req_ready  = grant_if;
    assign mem_req_ready = grant_mem;

    // With no grant the IF fields are driven so the port never floats to X.
    assign tlb_s_vppn     = grant_mem ? mem_vppn     : if_vppn;
    assign tlb_s_va_bit12 = grant_mem ? mem_va_bit12 : if_va_bit12;
    assign tlb_s_asid     = asid;

    // The starvation counter only counts MEM wins that actually kept a live IF
    // request waiting. Maintenance cycles freeze it so that fairness resumes where
    // it left off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!maint_busy) begin
            if (grant_if || !if_req_valid)
                starve_cnt <= '0;
            else if (grant_mem && if_elig && starve_cnt != LIMIT)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Response stage. The result is captured only on a grant and held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_pend     <= 1'b0;
            mem_pend    <= 1'b0;
            resp_result <= '0;
        end else begin
            if_pend  <= grant_if;
            mem_pend <= grant_mem;
            if (grant_if || grant_mem)
                resp_result <= tlb_s_result;
        end
    end

    // A flush in the response cycle kills the IF pulse, but the data still updates.
    assign if_resp_valid  = if_pend && !if_flush;
    assign mem_resp_valid = mem_pend;

endmodule

// File: tb/tb_tlb_search_arbiter.sv
module tb_tlb_search_arbiter;
    import tlb_search_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_valid, if_req_ready, if_va_bit12;
    logic [18:0] if_vppn;
    logic        mem_req_valid, mem_req_ready, mem_va_bit12;
    logic [18:0] mem_vppn;
    logic [9:0]  asid;
    logic        maint_busy, if_flush;
    logic [18:0] tlb_s_vppn;
    logic        tlb_s_va_bit12;
    logic [9:0]  tlb_s_asid;
    tlb_result_t tlb_s_result, resp_result;
    logic        if_resp_valid, mem_resp_valid;

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    // Reference TLB: a fixed, arbitrary mapping from the search key to a result.
    function automatic tlb_result_t tlb_model(input logic [18:0] vppn, input logic b12);
        tlb_result_t r;
        r.found = ~vppn[18];
        r.ppn   = {vppn, b12} ^ 20'hA5A5A;
        r.ps    = 6'd12;
        r.plv   = vppn[1:0];
        r.mat   = vppn[3:2];
        r.d     = b12;
        r.v     = vppn[4];
        return r;
    endfunction

    assign tlb_s_result = tlb_model(tlb_s_vppn, tlb_s_va_bit12);

    tlb_search_arbiter #(.STARVE_LIMIT(4), .ASID_W(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready),
        .if_vppn(if_vppn), .if_va_bit12(if_va_bit12),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_vppn(mem_vppn), .mem_va_bit12(mem_va_bit12),
        .asid(asid), .maint_busy(maint_busy), .if_flush(if_flush),
        .tlb_s_vppn(tlb_s_vppn), .tlb_s_va_bit12(tlb_s_va_bit12),
        .tlb_s_asid(tlb_s_asid), .tlb_s_result(tlb_s_result),
        .if_resp_valid(if_resp_valid), .mem_resp_valid(mem_resp_valid),
        .resp_result(resp_result)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rdy(input string tag, input logic e_if, input logic e_mem);
        chk({tag, ".if_rdy"}, 64'(if_req_ready), 64'(e_if));
        chk({tag, ".mem_rdy"}, 64'(mem_req_ready), 64'(e_mem));
    endtask

    task automatic chk_resp(input string tag, input logic e_if, input logic e_mem);
        chk({tag, ".if_rv"}, 64'(if_resp_valid), 64'(e_if));
        chk({tag, ".mem_rv"}, 64'(mem_resp_valid), 64'(e_mem));
    endtask

    logic [18:0] sv_vppn;
    logic        sv_b12, e_if;

    initial begin
        rst_n = 1'b0;
        if_req_valid = 0; if_vppn = '0; if_va_bit12 = 0;
        mem_req_valid = 0; mem_vppn = '0; mem_va_bit12 = 0;
        asid = 10'h3A5; maint_busy = 0; if_flush = 0;

        // Reset state
        #3;
        chk_resp("reset", 1'b0, 1'b0);
        chk("reset.result", 64'(resp_result), 64'd0);
        chk_rdy("reset", 1'b0, 1'b0);
        #10 rst_n = 1'b1;
        step();

        // 1. IF only
        if_req_valid = 1; if_vppn = 19'h12345; if_va_bit12 = 1;
        #1;
        chk_rdy("t1", 1'b1, 1'b0);
        chk("t1.vppn", 64'(tlb_s_vppn), 64'h12345);
        chk("t1.b12", 64'(tlb_s_va_bit12), 64'd1);
        step();
        if_req_valid = 0;
        chk_resp("t1", 1'b1, 1'b0);
        chk("t1.result", 64'(resp_result), 64'(tlb_model(19'h12345, 1'b1)));
        // With no request, the search port carries the IF fields.
        if_vppn = 19'h00777; if_va_bit12 = 0;
        #1;
        chk_rdy("idle", 1'b0, 1'b0);
        chk("idle.vppn", 64'(tlb_s_vppn), 64'h00777);
        step();
        chk_resp("idle", 1'b0, 1'b0);
        chk("idle.hold", 64'(resp_result), 64'(tlb_model(19'h12345, 1'b1)));

        // 2. Both requesters valid: M,M,M,M,I repeating
        if_req_valid = 1; if_vppn = 19'h0AAAA; if_va_bit12 = 0;
        mem_req_valid = 1; mem_va_bit12 = 1;
        for (int k = 0; k < 10; k++) begin
            e_if = (k % 5 == 4);
            mem_vppn = 19'(32'h50000 + k);
            #1;
            chk_rdy($sformatf("t2[%0d]", k), e_if, !e_if);
            sv_vppn = e_if ? if_vppn : mem_vppn;
            sv_b12  = e_if ? 1'b0 : 1'b1;
            chk($sformatf("t2[%0d].vppn", k), 64'(tlb_s_vppn), 64'(sv_vppn));
            step();
            chk_resp($sformatf("t2[%0d]", k), e_if, !e_if);
            chk($sformatf("t2[%0d].result", k), 64'(resp_result), 64'(tlb_model(sv_vppn, sv_b12)));
        end

        // 3. Maintenance holds the starvation count: two MEM wins, a busy window,
        //    then M,M,I.
        for (int k = 0; k < 2; k++) begin
            mem_vppn = 19'(32'h60000 + k);
            #1;
            chk_rdy($sformatf("t3pre[%0d]", k), 1'b0, 1'b1);
            step();
        end
        maint_busy = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk_rdy($sformatf("t3busy[%0d]", k), 1'b0, 1'b0);
            // The last MEM grant still responds in the first busy cycle.
            chk_resp($sformatf("t3busy[%0d]", k), 1'b0, k == 0);
            if (k == 0)
                chk("t3busy.result", 64'(resp_result), 64'(tlb_model(19'h60001, 1'b1)));
            step();
        end
        maint_busy = 0;
        for (int k = 0; k < 3; k++) begin
            e_if = (k == 2);
            #1;
            chk_rdy($sformatf("t3post[%0d]", k), e_if, !e_if);
            step();
        end
        mem_req_valid = 0; if_req_valid = 0;
        step();

        // 4. Flush: response squashed, data still captured
        if_req_valid = 1; if_vppn = 19'h1BEEF; if_va_bit12 = 1;
        #1;
        chk_rdy("t4", 1'b1, 1'b0);
        step();
        if_req_valid = 0; if_flush = 1;
        #1;
        chk_resp("t4flush", 1'b0, 1'b0);
        chk("t4.result", 64'(resp_result), 64'(tlb_model(19'h1BEEF, 1'b1)));
        // A flushed IF request loses the port and MEM takes it.
        if_req_valid = 1; mem_req_valid = 1; mem_vppn = 19'h02468; mem_va_bit12 = 0;
        #1;
        chk_rdy("t4flushgrant", 1'b0, 1'b1);
        step();
        mem_req_valid = 0;
        chk_resp("t4mem", 1'b0, 1'b1);
        #1;
        chk_rdy("t4ifonlyflush", 1'b0, 1'b0);
        if_flush = 0; if_vppn = 19'h0C0DE; if_va_bit12 = 0;
        #1;
        chk_rdy("t4next", 1'b1, 1'b0);
        step();
        if_req_valid = 0;
        chk_resp("t4next", 1'b1, 1'b0);
        chk("t4next.result", 64'(resp_result), 64'(tlb_model(19'h0C0DE, 1'b0)));
        step();

        // 5. Asynchronous reset while a grant is in progress
        mem_req_valid = 1; mem_vppn = 19'h13579; mem_va_bit12 = 1;
        #1;
        chk_rdy("t5", 1'b0, 1'b1);
        #1 rst_n = 0;
        #1;
        chk("t5.async_result", 64'(resp_result), 64'd0);
        chk_resp("t5async", 1'b0, 1'b0);
        mem_req_valid = 0;
        step();
        #1 rst_n = 1;
        step();
        chk_resp("t5after", 1'b0, 1'b0);
        chk("t5after.result", 64'(resp_result), 64'd0);

        // 6. ASID follows the input in the same cycle
        for (int k = 0; k < 4; k++) begin
            asid = 10'h3A5 ^ 10'(k * 37);
            if_req_valid = k[0];
            mem_req_valid = k[1];
            #1;
            chk($sformatf("t6[%0d].asid", k), 64'(tlb_s_asid), 64'(10'h3A5 ^ 10'(k * 37)));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
